// File: rtl/alt_vipcti_common_sample_assembler.sv
// Rebuilds parallel colour-plane samples from sequential (SD) or parallel (HD) plane beats.
// Optional ALT_VIPCTI_SAMPLE_ASSEMBLER_ERR_COUNT_EN adds a saturating misalignment counter (err_count).
module alt_vipcti_common_sample_assembler #(
    parameter int NUMBER_OF_COLOUR_PLANES      = 3,
    parameter int LOG2_NUMBER_OF_COLOUR_PLANES = 2,
    parameter int BPS                          = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  sclr,
    input  logic                                  hd_sdn,
    input  logic                                  in_valid,
    input  logic                                  in_sos,
    input  logic [BPS*NUMBER_OF_COLOUR_PLANES-1:0] in_data,
    output logic                                  out_valid,
    output logic [BPS*NUMBER_OF_COLOUR_PLANES-1:0] out_data,
    output logic                                  out_error,
    output logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0] sample_ticks,
    output logic                                  start_of_sample
`ifdef ALT_VIPCTI_SAMPLE_ASSEMBLER_ERR_COUNT_EN
    ,
    output logic [15:0]                           err_count
`endif
);

    localparam int N     = NUMBER_OF_COLOUR_PLANES;
    localparam int L     = LOG2_NUMBER_OF_COLOUR_PLANES;
    localparam int DW    = BPS * N;
    localparam int SLOTS = (N > 1) ? N - 1 : 1;
    localparam logic [L-1:0] LAST_IDX = L'(N - 1);

    logic [L-1:0]   idx_reg;
    logic [BPS-1:0] shadow_reg [SLOTS];
    logic [DW-1:0]  data_reg;
    logic           valid_reg;
    logic           error_reg;

    logic           parallel;
    logic           misaligned;
    logic [L-1:0]   eff_idx;
    logic [DW-1:0]  assembled;
    logic           sd_beat;

    // A single-plane stream is indistinguishable from parallel planes.
    assign parallel   = hd_sdn || (N == 1);
    assign misaligned = in_sos && (idx_reg != '0);
    assign eff_idx    = misaligned ? '0 : idx_reg;
    assign sd_beat    = !sclr && !parallel && in_valid;

    generate
        if (N > 1) begin : g_multi
            for (genvar gi = 0; gi < N - 1; gi++) begin : g_slot
                assign assembled[gi*BPS +: BPS] = shadow_reg[gi];

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        shadow_reg[gi] <= '0;
                    end else if (sd_beat && (eff_idx == L'(gi))) begin
                        shadow_reg[gi] <= in_data[BPS-1:0];
                    end
                end
            end
            assign assembled[DW-1 -: BPS] = in_data[BPS-1:0];
        end else begin : g_single
            assign assembled = in_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_reg[0] <= '0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            error_reg <= 1'b0;
        end else if (sclr) begin
            idx_reg   <= '0;
            valid_reg <= 1'b0;
            error_reg <= 1'b0;
        end else if (parallel) begin
            idx_reg   <= '0;
            error_reg <= 1'b0;
            valid_reg <= in_valid;
            if (in_valid) begin
                data_reg <= in_data;
            end
        end else if (in_valid) begin
            // A misplaced start-of-sample abandons the partial sample and restarts at plane 0.
            error_reg <= misaligned;
            if (eff_idx == LAST_IDX) begin
                data_reg  <= assembled;
                valid_reg <= 1'b1;
                idx_reg   <= '0;
            end else begin
                valid_reg <= 1'b0;
                idx_reg   <= eff_idx + 1'b1;
            end
        end else begin
            valid_reg <= 1'b0;
            error_reg <= 1'b0;
        end
    end

`ifdef ALT_VIPCTI_SAMPLE_ASSEMBLER_ERR_COUNT_EN
    logic [15:0] err_count_reg;

    // An SD resync keeps the error history; only an HD-mode clear wipes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_reg <= '0;
        end else if (sclr && hd_sdn) begin
            err_count_reg <= '0;
        end else if (sd_beat && misaligned && (err_count_reg != 16'hFFFF)) begin
            err_count_reg <= err_count_reg + 16'd1;
        end
    end

    assign err_count = err_count_reg;
`endif

    assign out_valid       = valid_reg;
    assign out_data        = data_reg;
    assign out_error       = error_reg;
    assign sample_ticks    = idx_reg;
    assign start_of_sample = (idx_reg == '0);

endmodule

// File: doc/alt_vipcti_common_sample_assembler.md
Name: alt_vipcti_common_sample_assembler

Overview:
- Receive-side counterpart of the output-side colour-plane sequencer in the clocked video path.
- Takes a video stream that carries one colour plane per valid beat (SD, sequential planes) or a whole sample per valid beat (HD, parallel planes), and rebuilds full parallel samples.
- Sits between the clocked-video-input sync/decode logic and the pixel FIFO writer.
- Reports the plane position and flags misaligned start-of-sample markers.

Parameters:
- NUMBER_OF_COLOUR_PLANES, 3, colour planes per sample; legal range 1..4.
- LOG2_NUMBER_OF_COLOUR_PLANES, 2, plane index width; must be at least 1 and hold NUMBER_OF_COLOUR_PLANES-1.
- BPS, 8, bits per colour plane symbol.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- sclr  in  1  synchronous clear (start of line/field resync).
- hd_sdn  in  1  1 = parallel planes (one sample per beat); 0 = sequential planes.
- in_valid  in  1  input beat qualifier.
- in_sos  in  1  start-of-sample marker; meaningful only with in_valid in SD mode.
- in_data  in  BPS*NUMBER_OF_COLOUR_PLANES  HD: full sample, plane 0 in the LSBs. SD: plane symbol in [BPS-1:0], upper bits ignored.
- out_valid  out  1  one-cycle pulse, a complete sample is on out_data.
- out_data  out  BPS*NUMBER_OF_COLOUR_PLANES  assembled sample, plane 0 in the LSBs; held until the next out_valid.
- out_error  out  1  one-cycle pulse on a misaligned in_sos.
- sample_ticks  out  LOG2_NUMBER_OF_COLOUR_PLANES  current plane index expected next.
- start_of_sample  out  1  high when sample_ticks == 0.

Behaviour:
Reset
- rst_n low (asynchronous) clears: plane index, shadow register, out_data, out_valid, out_error.
- Applies mid-sample as well; any partial sample is lost.

State
- Plane index idx, range 0..N-1 (N = NUMBER_OF_COLOUR_PLANES).
- Shadow register with N-1 plane slots.
- Registered outputs.

Priority per cycle: rst_n > sclr > in_valid.
- sclr=1: idx <= 0, out_valid <= 0, out_error <= 0. The in_valid beat in the same cycle is discarded. out_data is unchanged.

HD mode (hd_sdn=1), or N==1
- in_valid: out_data <= in_data, out_valid <= 1 on the next edge (latency 1 cycle).
- idx is forced to 0 every cycle; in_sos is ignored; out_error is always 0.

SD mode, beat with in_valid=1
- Effective index e = 0 if (in_sos && idx!=0), else idx.
- If in_sos && idx!=0: out_error <= 1; the partial shadow contents are abandoned.
- If e < N-1: shadow slot e <= in_data[BPS-1:0], idx <= e+1, out_valid <= 0.
- If e == N-1:
  - out_data <= {in_data[BPS-1:0], shadow slots N-2..0}.
  - out_valid <= 1; idx wraps to 0.
- in_sos with idx==0: normal beat, no error.

SD mode, no beat: idx holds; out_valid and out_error return to 0.

General rules
- Beats need not be contiguous; gaps of any length between planes are legal.
- hd_sdn changes only while sclr is asserted. If it toggles otherwise, idx is forced to 0 the cycle hd_sdn=1; no error is raised.
- No backpressure: the consumer accepts every out_valid. Maximum rate is 1 sample/cycle (HD) or 1 per N beats (SD).

Optional Feature:
ALT_VIPCTI_SAMPLE_ASSEMBLER_ERR_COUNT_EN
- Defined:
  - Adds output err_count[15:0], reset to 0.
  - Increments on each out_error pulse and saturates at 16'hFFFF.
  - Cleared by sclr only when hd_sdn=1; an SD resync keeps the history.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- N=3, BPS=8, SD: beats 0x11,0x22,0x33 (first with in_sos) -> one cycle after the third beat, out_valid=1, out_data=0x332211. sample_ticks goes 0,1,2,0.
- SD with idle gaps (0x11, 4 idle, 0x22, 2 idle, 0x33) -> exactly one out_valid, out_data=0x332211. No out_valid during the gaps.
- SD misalignment: 0xAA,0xBB, then in_sos with 0x01, then 0x02,0x03 -> out_error pulses one cycle after the 0x01 beat, out_data=0x030201, no sample containing 0xAA.
- HD: in_valid for 3 consecutive cycles with 0x010203, 0x040506, 0x070809 -> out_valid high 3 consecutive cycles, one cycle later, with the same values. sample_ticks stays 0.
- sclr coinciding with the second SD beat, then beats 0x44,0x55,0x66 -> the second beat is discarded, out_data=0x665544, out_error stays 0.
- rst_n asserted after one SD beat, then released -> out_valid=0, out_data=0, idx=0 immediately (asynchronous). The next three beats produce a correct sample.
